// File: rtl/stack_pkg.sv
// Shared types for the stack engine: op codes, error codes and FSM states.
// Optional macro STACK_ERR_LOCK_EN (see stack_engine) changes error handling only.
package stack_pkg;

   typedef enum logic [2:0] {
      OP_NOP     = 3'b000,
      OP_PUSH    = 3'b001,
      OP_POP     = 3'b010,
      OP_POP2    = 3'b011,
      OP_REPLACE = 3'b100,
      OP_BINOP   = 3'b101,
      OP_DUP     = 3'b110,
      OP_SWAP    = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_OVF  = 2'b01,
      ERR_UDF  = 2'b10
   } err_e;

   typedef enum logic {
      RUN    = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x DATA_WIDTH, two combinational reads, two synchronous
// writes (the second one exists so SWAP can exchange two entries in one edge).
// Storage is deliberately not reset.
module stack_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic [AW-1:0]         raddr0,
   input  logic [AW-1:0]         raddr1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   input  logic                  we0,
   input  logic [AW-1:0]         waddr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  we1,
   input  logic [AW-1:0]         waddr1,
   input  logic [DATA_WIDTH-1:0] wdata1
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Combinational reads; out-of-range addresses (non power-of-two DEPTH) read 0.
   always_comb begin
      rdata0 = '0;
      rdata1 = '0;
      if (int'(raddr0) < DEPTH) rdata0 = mem[raddr0];
      if (int'(raddr1) < DEPTH) rdata1 = mem[raddr1];
   end

   // Two independent write ports; the engine never targets the same address with both.
   always_ff @(posedge clk) begin
      if (we0 && (int'(waddr0) < DEPTH)) mem[waddr0] <= wdata0;
      if (we1 && (int'(waddr1) < DEPTH)) mem[waddr1] <= wdata1;
   end

endmodule

// File: rtl/stack_engine.sv
// Operand stack engine: typed ops, top/next read ports, occupancy and peak
// tracking, flush, and overflow/underflow detection.
// Optional macro STACK_ERR_LOCK_EN: a fault locks the engine until err_clr.
// Handshake: an op is taken on a rising edge where op_valid && op_ready; op_ready
// never depends on op_valid, and op/wdata only need to be stable in that cycle.
module stack_engine
   import stack_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 16,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  flush,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] top,
   output logic [DATA_WIDTH-1:0] next,
   output logic [CNT_W-1:0]      count,
   output logic [CNT_W-1:0]      peak,
   output logic                  empty,
   output logic                  full,
   output logic                  err,
   output logic [1:0]            err_code,
   output state_e                dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

   logic [CNT_W-1:0] count_q, count_d, peak_q, peak_d;
   logic             err_q, err_d;
   err_e             err_code_q, err_code_d;
   state_e           state_q, state_d;

   logic [AW-1:0]         a_top, a_next, a_new;
   logic [DATA_WIDTH-1:0] rd_top, rd_next;
   logic                  we0, we1;
   logic [AW-1:0]         waddr0, waddr1;
   logic [DATA_WIDTH-1:0] wdata0, wdata1;
   logic                  accept, legal, fault;
   err_e                  fault_code;

   assign a_top  = AW'(count_q - ONE);
   assign a_next = AW'(count_q - TWO);
   assign a_new  = AW'(count_q);

   stack_regfile #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rf (
      .clk    (clk),
      .raddr0 (a_top),
      .raddr1 (a_next),
      .rdata0 (rd_top),
      .rdata1 (rd_next),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1)
   );

`ifdef STACK_ERR_LOCK_EN
   assign op_ready = !flush && (state_q == RUN);
`else
   assign op_ready = !flush;
`endif

   assign accept = op_valid && op_ready;

   // Decode the op: legality, storage writes and next occupancy.
   always_comb begin
      legal      = 1'b1;
      fault_code = ERR_UDF;
      count_d    = count_q;
      we0        = 1'b0;
      we1        = 1'b0;
      waddr0     = a_new;
      waddr1     = a_next;
      wdata0     = wdata;
      wdata1     = rd_top;
      case (op_e'(op))
         OP_NOP: ;
         OP_PUSH: begin
            legal      = (count_q < DEPTH_C);
            fault_code = ERR_OVF;
            we0        = 1'b1;
            count_d    = count_q + ONE;
         end
         OP_POP: begin
            legal   = (count_q >= ONE);
            count_d = count_q - ONE;
         end
         OP_POP2: begin
            legal   = (count_q >= TWO);
            count_d = count_q - TWO;
         end
         OP_REPLACE: begin
            legal  = (count_q >= ONE);
            we0    = 1'b1;
            waddr0 = a_top;
         end
         OP_BINOP: begin
            legal   = (count_q >= TWO);
            we0     = 1'b1;
            waddr0  = a_next;
            count_d = count_q - ONE;
         end
         OP_DUP: begin
            legal      = (count_q >= ONE) && (count_q < DEPTH_C);
            fault_code = (count_q == DEPTH_C) ? ERR_OVF : ERR_UDF;
            we0        = 1'b1;
            wdata0     = rd_top;
            count_d    = count_q + ONE;
         end
         OP_SWAP: begin
            legal  = (count_q >= TWO);
            we0    = 1'b1;
            waddr0 = a_top;
            wdata0 = rd_next;
            we1    = 1'b1;
         end
         default: ;
      endcase
      fault = accept && !legal;
      if (!(accept && legal)) begin
         we0     = 1'b0;
         we1     = 1'b0;
         count_d = count_q;
      end
      if (flush) count_d = '0;
   end

   // Peak, error and FSM next-state logic.
   always_comb begin
      peak_d = flush ? '0 : ((count_d > peak_q) ? count_d : peak_q);
`ifdef STACK_ERR_LOCK_EN
      err_d      = err_q;
      err_code_d = err_code_q;
      state_d    = state_q;
      if (fault) begin
         err_d      = 1'b1;
         err_code_d = fault_code;
         state_d    = LOCKED;
      end else if (err_clr) begin
         err_d      = 1'b0;
         err_code_d = ERR_NONE;
         state_d    = RUN;
      end
`else
      err_d      = fault;
      err_code_d = err_code_q;
      state_d    = RUN;
      if (fault)                 err_code_d = fault_code;
      else if (err_clr || accept) err_code_d = ERR_NONE;
`endif
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         peak_q     <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         state_q    <= RUN;
      end else begin
         count_q    <= count_d;
         peak_q     <= peak_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         state_q    <= state_d;
      end
   end

   assign top       = (count_q >= ONE) ? rd_top  : '0;
   assign next      = (count_q >= TWO) ? rd_next : '0;
   assign count     = count_q;
   assign peak      = peak_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_C);
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine (DATA_WIDTH=32, DEPTH=4): directed plan then random ops
// against a queue-based reference model.
module tb_stack_engine;
   import stack_pkg::*;

   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          op_valid, op_ready, flush, err_clr, empty, full, err;
   logic [2:0]    op;
   logic [DW-1:0] wdata, top, next;
   logic [CNT_W-1:0] count, peak;
   logic [1:0]    err_code;
   state_e        dbg_state;

   int tests = 0;
   int fails = 0;

   // reference model
   logic [DW-1:0] stk[$];
   int            peak_m;
   bit            err_m;
   logic [1:0]    code_m;
   bit            locked_m;

   stack_engine #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op(op), .wdata(wdata), .flush(flush), .err_clr(err_clr),
      .top(top), .next(next), .count(count), .peak(peak), .empty(empty),
      .full(full), .err(err), .err_code(err_code), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ready_m(input bit f);
      return !f && !locked_m;
   endfunction

   task automatic model_reset();
      stk.delete();
      peak_m = 0; err_m = 0; code_m = 2'b00; locked_m = 0;
   endtask

   task automatic model_step(input bit v, input logic [2:0] o, input logic [DW-1:0] d,
                             input bit f, input bit ec);
      int n;
      bit acc, fault;
      logic [1:0] c;
      logic [DW-1:0] t;
      n = stk.size();
      acc = v && ready_m(f);
      fault = 0;
      c = 2'b10;
      if (f) begin
         stk.delete();
         peak_m = 0;
      end else if (acc) begin
         case (o)
            3'd1: if (n < DEPTH) stk.push_back(d); else begin fault = 1; c = 2'b01; end
            3'd2: if (n >= 1) void'(stk.pop_back()); else fault = 1;
            3'd3: if (n >= 2) begin void'(stk.pop_back()); void'(stk.pop_back()); end else fault = 1;
            3'd4: if (n >= 1) stk[n-1] = d; else fault = 1;
            3'd5: if (n >= 2) begin void'(stk.pop_back()); stk[n-2] = d; end else fault = 1;
            3'd6: if (n == 0) fault = 1;
                  else if (n == DEPTH) begin fault = 1; c = 2'b01; end
                  else stk.push_back(stk[n-1]);
            3'd7: if (n >= 2) begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
                  else fault = 1;
            default: ;
         endcase
         if (stk.size() > peak_m) peak_m = stk.size();
      end
`ifdef STACK_ERR_LOCK_EN
      if (fault) begin err_m = 1; code_m = c; locked_m = 1; end
      else if (ec) begin err_m = 0; code_m = 2'b00; locked_m = 0; end
`else
      err_m = fault;
      if (fault) code_m = c;
      else if (ec || acc) code_m = 2'b00;
`endif
   endtask

   task automatic check_all(input string tag);
      int n;
      n = stk.size();
      chk({tag, ".top"},   top,   (n >= 1) ? stk[n-1] : 32'h0);
      chk({tag, ".next"},  next,  (n >= 2) ? stk[n-2] : 32'h0);
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".peak"},  32'(peak),  32'(peak_m));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
      chk({tag, ".err"},   32'(err),   32'(err_m));
      chk({tag, ".code"},  32'(err_code), 32'(code_m));
      chk({tag, ".ready"}, 32'(op_ready), 32'(ready_m(0)));
   endtask

   // driver: apply one cycle of inputs, clock it, update model and check
   task automatic step(input string tag, input bit v, input logic [2:0] o,
                       input logic [DW-1:0] d, input bit f, input bit ec);
      op_valid = v; op = o; wdata = d; flush = f; err_clr = ec;
      #1;
      chk({tag, ".ready_pre"}, 32'(op_ready), 32'(ready_m(f)));
      @(posedge clk);
      model_step(v, o, d, f, ec);
      #1;
      op_valid = 0; op = 3'd0; wdata = '0; flush = 0; err_clr = 0;
      #1;
      check_all(tag);
   endtask

   initial begin
      op_valid = 0; op = 3'd0; wdata = '0; flush = 0; err_clr = 0;
      rst_n = 0;
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1;
      @(posedge clk); #1;

      // 1: pushes
      step("p11", 1, OP_PUSH, 32'h11, 0, 0);
      step("p22", 1, OP_PUSH, 32'h22, 0, 0);
      step("p33", 1, OP_PUSH, 32'h33, 0, 0);
      chk("t1.top_const", top, 32'h33);
      chk("t1.peak_const", 32'(peak), 32'd3);
      // 2: binop, swap, dup
      step("binop", 1, OP_BINOP, 32'h55, 0, 0);
      chk("t2.binop_top", top, 32'h55);
      chk("t2.binop_next", next, 32'h11);
      step("swap", 1, OP_SWAP, 32'h0, 0, 0);
      chk("t2.swap_top", top, 32'h11);
      chk("t2.swap_next", next, 32'h55);
      step("dup", 1, OP_DUP, 32'h0, 0, 0);
      chk("t2.dup_top", top, 32'h11);
      // 3: fill, overflow
      step("fill", 1, OP_PUSH, 32'h77, 0, 0);
      step("ovf", 1, OP_PUSH, 32'h99, 0, 0);
      chk("t3.ovf_code", 32'(err_code), 32'd1);
      chk("t3.ovf_top", top, 32'h77);
`ifdef STACK_ERR_LOCK_EN
      step("locked_push", 1, OP_POP, 32'h0, 0, 0);
      step("locked_idle", 0, OP_NOP, 32'h0, 0, 0);
      step("unlock", 0, OP_NOP, 32'h0, 0, 1);
      chk("t3.ready_after_clr", 32'(op_ready), 32'd1);
`else
      step("after_ovf", 0, OP_NOP, 32'h0, 0, 0);
`endif
      // 4: empty then underflow
      step("pop2a", 1, OP_POP2, 32'h0, 0, 0);
      step("pop2b", 1, OP_POP2, 32'h0, 0, 0);
      step("udf_pop2", 1, OP_POP2, 32'h0, 0, 0);
      chk("t4.udf_code", 32'(err_code), 32'd2);
      step("clr1", 0, OP_NOP, 32'h0, 0, 1);
      step("udf_dup", 1, OP_DUP, 32'h0, 0, 0);
      chk("t4.dup_udf_code", 32'(err_code), 32'd2);
      step("clr2", 0, OP_NOP, 32'h0, 0, 1);
      // 5: flush beats push
      step("f1", 1, OP_PUSH, 32'hA1, 0, 0);
      step("f2", 1, OP_PUSH, 32'hA2, 0, 0);
      step("f3", 1, OP_PUSH, 32'hA3, 0, 0);
      step("flush_push", 1, OP_PUSH, 32'hA4, 1, 0);
      chk("t5.count", 32'(count), 32'd0);
      // 6: async reset between edges
      step("r1", 1, OP_PUSH, 32'hB1, 0, 0);
      step("r2", 1, OP_PUSH, 32'hB2, 0, 0);
      #2;
      rst_n = 0;
      model_reset();
      #1;
      chk("t6.count_async", 32'(count), 32'd0);
      chk("t6.peak_async", 32'(peak), 32'd0);
      chk("t6.err_async", 32'(err), 32'd0);
      check_all("t6.async");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      step("p7", 1, OP_PUSH, 32'h7, 0, 0);
      chk("t6.top7", top, 32'h7);
      chk("t6.next0", next, 32'h0);

      // random section
      for (int i = 0; i < 400; i++) begin
         step("rnd", $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised hardware operand stack for the next-generation stack-machine datapath.
- Replaces ad hoc stack-pointer and stack-memory handling with one clocked block.
- Provides a typed op set (push/pop/pop2/replace/binop/dup/swap), top and next-top read ports, occupancy tracking, peak-depth tracking, flush, and overflow/underflow detection with an error FSM.
- Sits between decode/control and the ALU/data-memory write-back mux.

Parameters:
- DATA_WIDTH, 32, entry width in bits; 16 and 32 are supported.
- DEPTH, 16, number of stack entries; must be at least 2; need not be a power of two.
- CNT_W, $clog2(DEPTH+1), localparam; width of the occupancy and peak counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  op request.
- op_ready  out  1  op accepted when op_valid && op_ready.
- op  in  3  operation code (see Behaviour).
- wdata  in  DATA_WIDTH  data for PUSH, REPLACE and BINOP.
- flush  in  1  synchronous clear of the stack.
- err_clr  in  1  clears the error state.
- top  out  DATA_WIDTH  entry at count-1; 0 if count < 1.
- next  out  DATA_WIDTH  entry at count-2; 0 if count < 2.
- count  out  CNT_W  current occupancy.
- peak  out  CNT_W  highest occupancy since reset or flush.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err  out  1  error flag.
- err_code  out  2  00 none, 01 overflow, 10 underflow.

Behaviour:
- Reset (async, rst_n low):
  - count = 0, peak = 0, err = 0, err_code = 00, FSM = RUN.
  - Storage is not cleared; top and next read 0 because count is 0.
- Latency: an op accepted at edge N is reflected in top, next and count after edge N. top and next are combinational reads of storage at count-1 and count-2.
- Ops (each is legal only when its precondition holds; the precondition follows the op name):
  - 000 NOP: always legal; no effect.
  - 001 PUSH, count < DEPTH: mem[count] = wdata; count + 1.
  - 010 POP, count >= 1: count - 1.
  - 011 POP2, count >= 2: count - 2.
  - 100 REPLACE, count >= 1: mem[count-1] = wdata.
  - 101 BINOP, count >= 2: mem[count-2] = wdata; count - 1. This pops two entries and pushes the ALU result.
  - 110 DUP, 1 <= count < DEPTH: mem[count] = mem[count-1]; count + 1.
  - 111 SWAP, count >= 2: exchange mem[count-1] and mem[count-2] in one edge.
- Faulting ops:
  - An accepted op whose precondition fails leaves storage and count untouched.
  - err is set to 1. err_code is set to 01 if the op needed free space (PUSH with count == DEPTH, or DUP with count == DEPTH); otherwise 10.
  - DUP with count == 0 is an underflow.
- peak: updated to count_next whenever count_next > peak.
- flush:
  - Next edge: count = 0, peak = 0.
  - op_ready is 0 while flush is high; flush has priority over any op.
  - err is not affected by flush.
- err_clr: next edge err = 0, err_code = 00. If a new fault occurs on the same edge, the new fault wins.
- FSM states: RUN and LOCKED. Transition behaviour depends on the optional feature below.
- No wrap-around: count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: STACK_ERR_LOCK_EN.
- Defined:
  - A fault moves the FSM RUN -> LOCKED.
  - In LOCKED, op_ready = 0 and err stays 1.
  - err_clr moves LOCKED -> RUN on the next edge; op_ready is 1 in the following cycle.
  - flush is still honoured in LOCKED.
- Undefined:
  - The FSM never leaves RUN.
  - op_ready = !flush.
  - err is a one-cycle pulse in the cycle after the faulting op; err_code holds until the next accepted op or err_clr.

Decomposition:
- Shared package stack_pkg:
  - op enum (NOP ... SWAP).
  - err_code enum (ERR_NONE, ERR_OVF, ERR_UDF).
  - FSM state enum (RUN, LOCKED).
- Sub-module stack_regfile:
  - DEPTH x DATA_WIDTH storage.
  - Two combinational read ports.
  - Two synchronous write ports, required for SWAP.
  - No reset.

Test Plan (DATA_WIDTH = 32, DEPTH = 4):
1. PUSH 0x11, 0x22, 0x33 -> top = 0x33, next = 0x22, count = 3, peak = 3, empty = 0, full = 0.
2. Continuing: BINOP wdata = 0x55 -> top = 0x55, next = 0x11, count = 2. SWAP -> top = 0x11, next = 0x55. DUP -> count = 3, top = 0x11.
3. Fill to 4, then PUSH 0x99 -> full = 1, count stays 4, err = 1, err_code = 01, top unchanged.
   - With STACK_ERR_LOCK_EN: op_ready = 0 until err_clr, and ready returns one cycle after the err_clr edge.
4. Empty stack, then POP2 -> err_code = 10, count = 0, top = 0, next = 0. DUP on empty -> err_code = 10.
5. count = 3 with flush and op_valid (PUSH) in the same cycle -> op_ready = 0, count = 0, peak = 0, PUSH dropped, err unchanged.
6. Deassert rst_n mid-sequence between edges (count = 2) -> count, peak and err clear immediately without waiting for clk. After release, PUSH 0x7 -> top = 0x7, next = 0.
